// File: rtl/prog_clkdiv.sv
// prog_clkdiv: NCH independent programmable clock dividers with shadowed divisors,
// global phase-align strobe and bad-channel write flag. Macro PROG_CLKDIV_TICK_EN enables tick outputs.
module prog_clkdiv #(
  parameter int unsigned NCH     = 4,
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned DEF_DIV = 100,
  localparam int unsigned CH_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             CLK_IN,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [CH_W-1:0]  wr_ch,
  input  logic [CNT_W-1:0] wr_div,
  input  logic             sync,
  output logic [NCH-1:0]   CLK_OUT,
  output logic [NCH-1:0]   tick,
  output logic [NCH-1:0]   pend,
  output logic             wr_err
);

  localparam logic [CNT_W-1:0] DEF_DIV_C = CNT_W'(DEF_DIV);

  logic [NCH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NCH-1:0][CNT_W-1:0] div_a_q, div_a_d;
  logic [NCH-1:0][CNT_W-1:0] div_s_q, div_s_d;
  logic [NCH-1:0]            clk_q, clk_d;
  logic [NCH-1:0]            pend_q, pend_d;
  logic [NCH-1:0]            tgl_c;
  logic                      wr_err_q, wr_err_d;
  logic                      wr_ok_c;

  assign wr_ok_c  = wr_en && (32'(wr_ch) < NCH);
  assign wr_err_d = wr_en && (32'(wr_ch) >= NCH);

  // Per-channel counter, shadow-divisor hand-off and output toggle.
  always_comb begin
    cnt_d   = cnt_q;
    div_a_d = div_a_q;
    div_s_d = div_s_q;
    pend_d  = pend_q;
    clk_d   = clk_q;
    tgl_c   = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (sync || (div_a_q[i] == '0)) begin
        cnt_d[i] = '0;
        clk_d[i] = 1'b0;
        if (pend_q[i]) begin
          div_a_d[i] = div_s_q[i];
          pend_d[i]  = 1'b0;
        end
      end else if (cnt_q[i] == div_a_q[i]) begin
        cnt_d[i] = '0;
        if (pend_q[i]) begin
          div_a_d[i] = div_s_q[i];
          pend_d[i]  = 1'b0;
        end
        // A zero divisor landing at terminal parks the output low without a tick.
        if (pend_q[i] && (div_s_q[i] == '0)) begin
          clk_d[i] = 1'b0;
        end else begin
          clk_d[i] = ~clk_q[i];
          tgl_c[i] = 1'b1;
        end
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
      // A new write is captured after any apply above, so it waits for the next terminal.
      if (wr_ok_c && (wr_ch == CH_W'(i))) begin
        div_s_d[i] = wr_div;
        pend_d[i]  = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK_IN or posedge clr) begin
    if (clr) begin
      cnt_q    <= '0;
      div_a_q  <= {NCH{DEF_DIV_C}};
      div_s_q  <= {NCH{DEF_DIV_C}};
      clk_q    <= '0;
      pend_q   <= '0;
      wr_err_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      div_a_q  <= div_a_d;
      div_s_q  <= div_s_d;
      clk_q    <= clk_d;
      pend_q   <= pend_d;
      wr_err_q <= wr_err_d;
    end
  end

`ifdef PROG_CLKDIV_TICK_EN
  logic [NCH-1:0] tick_q;

  always_ff @(posedge CLK_IN or posedge clr) begin
    if (clr) begin
      tick_q <= '0;
    end else begin
      tick_q <= tgl_c;
    end
  end

  assign tick = tick_q;
`else
  assign tick = '0;
`endif

  assign CLK_OUT = clk_q;
  assign pend    = pend_q;
  assign wr_err  = wr_err_q;

endmodule
